// File: rtl/fu_issue_tracker.sv
// Tracks a pool of NUM_FU non-pipelined multi-cycle FUs: per-FU IDLE/BUSY/DONE FSM, latency counter, held result tag.
// Optional FU_READY_BYPASS_EN lets a DONE FU being acked accept a new issue in the same cycle.
module fu_issue_tracker #(
  parameter int NUM_FU  = 2,
  parameter int LATENCY = 4,
  parameter int TAG_W   = 6
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_FU-1:0]              issue_valid,
  input  logic [NUM_FU*TAG_W-1:0]        issue_tag,
  input  logic                           squash,
  input  logic [NUM_FU-1:0]              done_ack,
  output logic [NUM_FU-1:0]              fu_ready,
  output logic [$clog2(NUM_FU+1)-1:0]    num_free,
  output logic [NUM_FU-1:0]              done_valid,
  output logic [NUM_FU*TAG_W-1:0]        done_tag,
  output logic [2*NUM_FU-1:0]            dbg_state
);

  // Handshake: issue_valid[i] is taken only while fu_ready[i] is high and squash is low;
  // a result is presented on done_valid[i]/done_tag and held unchanged until done_ack[i].

  localparam int NF_W  = $clog2(NUM_FU+1);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY+1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY >= 2) ? CNT_W'(LATENCY-2) : '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state   [NUM_FU];
  state_t             w_state_nxt [NUM_FU];
  logic [CNT_W-1:0]   r_cnt     [NUM_FU];
  logic [CNT_W-1:0]   w_cnt_nxt [NUM_FU];
  logic [TAG_W-1:0]   r_tag     [NUM_FU];
  logic [TAG_W-1:0]   w_tag_nxt [NUM_FU];
  logic [NUM_FU-1:0]  w_ready;
  logic [NUM_FU-1:0]  w_accept;
  logic [NF_W-1:0]    w_free;

  always_comb begin
    w_ready = '0;
    for (int i = 0; i < NUM_FU; i++) begin
`ifdef FU_READY_BYPASS_EN
      w_ready[i] = (r_state[i] == S_IDLE) ||
                   ((r_state[i] == S_DONE) && done_ack[i] && !squash);
`else
      w_ready[i] = (r_state[i] == S_IDLE);
`endif
    end
  end

  always_comb begin
    w_accept = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      w_tag_nxt[i]   = r_tag[i];
      w_accept[i]    = issue_valid[i] && w_ready[i] && !squash;
      if (squash) begin
        w_state_nxt[i] = S_IDLE;
        w_cnt_nxt[i]   = '0;
      end else if (w_accept[i]) begin
        w_tag_nxt[i] = issue_tag[i*TAG_W +: TAG_W];
        w_cnt_nxt[i] = CNT_INIT;
        if (LATENCY == 1) w_state_nxt[i] = S_DONE;
        else              w_state_nxt[i] = S_BUSY;
      end else begin
        case (r_state[i])
          S_BUSY: begin
            if (r_cnt[i] == '0) w_state_nxt[i] = S_DONE;
            else                w_cnt_nxt[i]   = r_cnt[i] - CNT_W'(1);
          end
          S_DONE: begin
            if (done_ack[i]) w_state_nxt[i] = S_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_FU; i++) begin
        r_state[i] <= S_IDLE;
        r_cnt[i]   <= '0;
        r_tag[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
        r_tag[i]   <= w_tag_nxt[i];
      end
    end
  end

  // Result outputs decode registered state only, so no input reaches them combinationally.
  always_comb begin
    w_free     = '0;
    done_valid = '0;
    done_tag   = '0;
    dbg_state  = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      w_free                       = w_free + NF_W'(w_ready[i]);
      done_valid[i]                = (r_state[i] == S_DONE);
      done_tag[i*TAG_W +: TAG_W]   = r_tag[i];
      dbg_state[2*i +: 2]          = r_state[i];
    end
  end

  assign fu_ready = w_ready;
  assign num_free = w_free;

endmodule

// File: tb/tb_fu_issue_tracker.sv
// Random and directed stimulus for fu_issue_tracker against an occupancy/due-cycle reference model;
// a separate monitor matches every presented result against the expected-result queue.
module tb_fu_issue_tracker;

  localparam int NUM_FU = 2;
  localparam int LAT    = 4;
  localparam int TAG_W  = 6;
  localparam int NF_W   = 2;
  localparam int EW     = 32 + TAG_W + 1;

  logic                      clock = 1'b0;
  logic                      reset;
  logic [NUM_FU-1:0]         issue_valid;
  logic [NUM_FU*TAG_W-1:0]   issue_tag;
  logic                      squash;
  logic [NUM_FU-1:0]         done_ack;
  logic [NUM_FU-1:0]         fu_ready;
  logic [NF_W-1:0]           num_free;
  logic [NUM_FU-1:0]         done_valid;
  logic [NUM_FU*TAG_W-1:0]   done_tag;
  logic [2*NUM_FU-1:0]       dbg_state;

  logic [NUM_FU-1:0]         l1_issue_valid;
  logic [NUM_FU*TAG_W-1:0]   l1_issue_tag;
  logic                      l1_squash;
  logic [NUM_FU-1:0]         l1_done_ack;
  logic [NUM_FU-1:0]         l1_fu_ready;
  logic [NF_W-1:0]           l1_num_free;
  logic [NUM_FU-1:0]         l1_done_valid;
  logic [NUM_FU*TAG_W-1:0]   l1_done_tag;
  logic [2*NUM_FU-1:0]       l1_dbg_state;

  fu_issue_tracker #(.NUM_FU(NUM_FU), .LATENCY(LAT), .TAG_W(TAG_W)) u_dut (
    .clock(clock), .reset(reset), .issue_valid(issue_valid), .issue_tag(issue_tag),
    .squash(squash), .done_ack(done_ack), .fu_ready(fu_ready), .num_free(num_free),
    .done_valid(done_valid), .done_tag(done_tag), .dbg_state(dbg_state)
  );

  fu_issue_tracker #(.NUM_FU(NUM_FU), .LATENCY(1), .TAG_W(TAG_W)) u_dut_l1 (
    .clock(clock), .reset(reset), .issue_valid(l1_issue_valid), .issue_tag(l1_issue_tag),
    .squash(l1_squash), .done_ack(l1_done_ack), .fu_ready(l1_fu_ready), .num_free(l1_num_free),
    .done_valid(l1_done_valid), .done_tag(l1_done_tag), .dbg_state(l1_dbg_state)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];   // {due_cycle, tag, fu}
  logic          occ [NUM_FU];
  int            due [NUM_FU];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < NUM_FU; i++) begin
      occ[i] = 1'b0;
      due[i] = 0;
    end
    exp_q.delete();
  endtask

  // ---------------- driver with reference model ----------------
  task automatic drive_cycle(input logic [NUM_FU-1:0] iv, input logic [NUM_FU*TAG_W-1:0] tags,
                             input logic [NUM_FU-1:0] ack, input logic sq);
    logic [NUM_FU-1:0] held;
    logic [NUM_FU-1:0] exp_rdy;
    @(negedge clock);
    for (int i = 0; i < NUM_FU; i++) begin
      held[i]    = occ[i] && (cyc >= due[i]);
      exp_rdy[i] = !occ[i];
`ifdef FU_READY_BYPASS_EN
      if (held[i] && ack[i] && !sq) exp_rdy[i] = 1'b1;
`endif
    end
    issue_valid = iv;
    issue_tag   = tags;
    done_ack    = ack;
    squash      = sq;
    #1;
    check("fu_ready", 32'(fu_ready), 32'(exp_rdy));
    check("num_free", 32'(num_free), 32'($countones(exp_rdy)));
    check("done_valid", 32'(done_valid), 32'(held));
    for (int i = 0; i < NUM_FU; i++) begin
      if (sq) begin
        occ[i] = 1'b0;
      end else begin
        if (held[i] && ack[i]) occ[i] = 1'b0;
        if (exp_rdy[i] && iv[i]) begin
          occ[i] = 1'b1;
          due[i] = cyc + LAT;
          exp_q.push_back({32'(due[i]), tags[i*TAG_W +: TAG_W], 1'(i)});
        end
      end
    end
    if (sq) exp_q.delete();
  endtask

  task automatic idle(input int n, input logic [NUM_FU-1:0] ack);
    for (int k = 0; k < n; k++) drive_cycle('0, '0, ack, 1'b0);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [NUM_FU-1:0] prev_dv;
    logic [TAG_W-1:0]  held_tag [NUM_FU];
    logic [TAG_W-1:0]  cur_tag;
    logic [EW-1:0]     entry;
    int                idx;
    prev_dv = '0;
    for (int i = 0; i < NUM_FU; i++) held_tag[i] = '0;
    forever begin
      @(negedge clock);
      for (int i = 0; i < NUM_FU; i++) begin
        cur_tag = done_tag[i*TAG_W +: TAG_W];
        if (done_valid[i] && !prev_dv[i]) begin
          idx = -1;
          for (int k = 0; k < exp_q.size(); k++)
            if (idx < 0 && exp_q[k][0] == 1'(i)) idx = k;
          if (idx < 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: fu %0d tag 0x%0h with no expected entry (cycle %0d)",
                     i, cur_tag, cyc);
          end else begin
            entry = exp_q[idx];
            exp_q.delete(idx);
            check("result_tag", 32'(cur_tag), 32'(entry[TAG_W:1]));
            check("result_cycle", 32'(cyc), entry[EW-1:TAG_W+1]);
          end
          held_tag[i] = cur_tag;
        end else if (done_valid[i] && prev_dv[i]) begin
          check("held_tag", 32'(cur_tag), 32'(held_tag[i]));
        end
      end
      prev_dv = done_valid;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    reset          = 1'b1;
    issue_valid    = '0;
    issue_tag      = '0;
    squash         = 1'b0;
    done_ack       = '0;
    l1_issue_valid = '0;
    l1_issue_tag   = '0;
    l1_squash      = 1'b0;
    l1_done_ack    = '0;
    reset_model();
    #3;
    check("rst_fu_ready", 32'(fu_ready), 32'h3);
    check("rst_num_free", 32'(num_free), 32'd2);
    check("rst_done_valid", 32'(done_valid), 32'h0);
    check("rst_done_tag", 32'(done_tag), 32'h0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // LATENCY=1 instance: issue, then ack + reissue in the done cycle
    @(negedge clock);
    l1_issue_valid = 2'b01;
    l1_issue_tag   = {6'h00, 6'h2A};
    @(negedge clock);
    check("l1_done_valid_t1", 32'(l1_done_valid), 32'h1);
    check("l1_done_tag_t1", 32'(l1_done_tag[5:0]), 32'h2A);
    l1_done_ack    = 2'b01;
    l1_issue_valid = 2'b01;
    l1_issue_tag   = {6'h00, 6'h11};
    #1;
`ifdef FU_READY_BYPASS_EN
    check("l1_fu_ready_t1", 32'(l1_fu_ready[0]), 32'h1);
`else
    check("l1_fu_ready_t1", 32'(l1_fu_ready[0]), 32'h0);
`endif
    @(negedge clock);
    l1_done_ack    = '0;
    l1_issue_valid = '0;
    #1;
`ifdef FU_READY_BYPASS_EN
    check("l1_done_valid_t2", 32'(l1_done_valid), 32'h1);
    check("l1_done_tag_t2", 32'(l1_done_tag[5:0]), 32'h11);
    l1_done_ack = 2'b01;
    @(negedge clock);
    l1_done_ack = '0;
    #1;
`else
    check("l1_done_valid_t2", 32'(l1_done_valid), 32'h0);
`endif
    check("l1_fu_ready_end", 32'(l1_fu_ready), 32'h3);

    // basic issue, ack two cycles after done
    drive_cycle(2'b01, {6'h00, 6'h15}, 2'b00, 1'b0);
    idle(5, 2'b00);
    drive_cycle('0, '0, 2'b01, 1'b0);
    idle(2, 2'b00);

    // backpressure: result held well beyond ten cycles
    drive_cycle(2'b01, {6'h00, 6'h22}, 2'b00, 1'b0);
    idle(LAT + 11, 2'b00);
    drive_cycle('0, '0, 2'b01, 1'b0);
    idle(1, 2'b00);

    // squash with both FUs busy and a same-cycle issue
    drive_cycle(2'b11, {6'h09, 6'h05}, 2'b00, 1'b0);
    idle(1, 2'b00);
    drive_cycle(2'b11, {6'h3C, 6'h3B}, 2'b00, 1'b1);
    idle(LAT + 2, 2'b00);

    // illegal issue while FU0 busy
    drive_cycle(2'b01, {6'h00, 6'h15}, 2'b00, 1'b0);
    drive_cycle(2'b01, {6'h00, 6'h3F}, 2'b00, 1'b0);
    idle(LAT, 2'b00);
    drive_cycle('0, '0, 2'b01, 1'b0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      drive_cycle(NUM_FU'($urandom_range(0, 3)),
                  {6'($urandom_range(0, 63)), 6'($urandom_range(0, 63))},
                  NUM_FU'($urandom_range(0, 3)),
                  ($urandom_range(0, 24) == 0));
    end
    idle(LAT + 3, 2'b11);

    // asynchronous reset while both FUs are busy
    drive_cycle(2'b11, {6'h2D, 6'h1E}, 2'b00, 1'b0);
    idle(2, 2'b00);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_fu_ready", 32'(fu_ready), 32'h3);
    check("mid_rst_num_free", 32'(num_free), 32'd2);
    check("mid_rst_done_valid", 32'(done_valid), 32'h0);
    check("mid_rst_done_tag", 32'(done_tag), 32'h0);
    reset_model();
    @(negedge clock);
    reset = 1'b0;
    idle(LAT + 2, 2'b00);

    check("pending_results", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
